// File: rtl/z_core_div_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default widths.
package z_core_div_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int TAG_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/z_core_div_sign_fix.sv
// Conditional two's-complement negation of a pair of values; used both to take
// operand magnitudes and to restore the sign of quotient/remainder.
module z_core_div_sign_fix
    import z_core_div_pkg::*;
#(
    parameter int W = XLEN_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic         neg_a,
    input  logic [W-1:0] b,
    input  logic         neg_b,
    output logic [W-1:0] a_fix,
    output logic [W-1:0] b_fix
);

    assign a_fix = neg_a ? ((~a) + W'(1)) : a;
    assign b_fix = neg_b ? ((~b) + W'(1)) : b;

endmodule

// File: rtl/z_core_div_unit_p.sv
// Restoring radix-2 divider (RISC-V DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define Z_CORE_DIV_EARLY_OUT_EN to skip the iteration for divide-by-zero and signed overflow.
module z_core_div_unit_p
    import z_core_div_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  dividend,
    input  logic [XLEN-1:0]  divisor,
    input  logic             is_signed,
    input  logic             quotient_or_rem,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t state, state_nx;

    logic [XLEN-1:0]  quo, rem, dsr, dvd_raw, result_r;
    logic [TAG_W-1:0] tag_r;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, sel_q, div_zero, ovf;

    logic             accept, last, early;
    logic             in_zero, in_ovf;
    logic [XLEN-1:0]  dvd_abs, dsr_abs, q_fix, r_fix, fix_val;
    logic [XLEN:0]    shifted, trial;

    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state == DONE);
    assign result    = result_r;
    assign out_tag   = tag_r;

    assign in_zero = (divisor == '0);
    assign in_ovf  = is_signed && (dividend == MIN_NEG) && (&divisor);
    assign last    = (cnt == CW'(XLEN - 1));

`ifdef Z_CORE_DIV_EARLY_OUT_EN
    assign early = in_zero || in_ovf;
`else
    assign early = 1'b0;
`endif

    z_core_div_sign_fix #(.W(XLEN)) u_op_fix (
        .a     (dividend),
        .neg_a (is_signed && dividend[XLEN-1]),
        .b     (divisor),
        .neg_b (is_signed && divisor[XLEN-1]),
        .a_fix (dvd_abs),
        .b_fix (dsr_abs)
    );

    z_core_div_sign_fix #(.W(XLEN)) u_res_fix (
        .a     (quo),
        .neg_a (neg_q),
        .b     (rem),
        .neg_b (neg_r),
        .a_fix (q_fix),
        .b_fix (r_fix)
    );

    // Partial remainder shifted left with the next dividend bit; a set top bit
    // after subtraction means the divisor did not fit (restore).
    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, dsr};

    always_comb begin
        fix_val = sel_q ? q_fix : r_fix;
        if (div_zero)
            fix_val = sel_q ? '1 : dvd_raw;
        else if (ovf)
            fix_val = sel_q ? MIN_NEG : '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = early ? FIXUP : CALC;
            CALC:    if (last) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo      <= '0;
            rem      <= '0;
            dsr      <= '0;
            dvd_raw  <= '0;
            result_r <= '0;
            tag_r    <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            sel_q    <= 1'b0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (accept) begin
                quo      <= dvd_abs;
                dsr      <= dsr_abs;
                rem      <= '0;
                cnt      <= '0;
                dvd_raw  <= dividend;
                neg_q    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
                neg_r    <= is_signed && dividend[XLEN-1];
                sel_q    <= quotient_or_rem;
                div_zero <= in_zero;
                ovf      <= in_ovf;
                tag_r    <= in_tag;
            end else if (state == CALC && !flush) begin
                cnt <= cnt + CW'(1);
                if (!trial[XLEN]) begin
                    rem <= trial[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b1};
                end else begin
                    rem <= shifted[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], 1'b0};
                end
            end
            if (state == FIXUP && !flush)
                result_r <= fix_val;
        end
    end

endmodule

// File: tb/tb_z_core_div_unit_p.sv
// Directed bench for the divider: scoreboard of expected results, 32- and 64-bit instances.
module tb_z_core_div_unit_p;

`ifdef Z_CORE_DIV_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid, in_ready, is_signed, quotient_or_rem, flush, out_valid, out_ready;
    logic [31:0] dividend, divisor, result;
    logic [4:0]  in_tag, out_tag;

    logic        w_in_valid, w_in_ready, w_is_signed, w_quotient_or_rem, w_flush, w_out_valid, w_out_ready;
    logic [63:0] w_dividend, w_divisor, w_result;
    logic [4:0]  w_in_tag, w_out_tag;

    z_core_div_unit_p #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
        .quotient_or_rem(quotient_or_rem), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag)
    );

    z_core_div_unit_p #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .dividend(w_dividend), .divisor(w_divisor), .is_signed(w_is_signed),
        .quotient_or_rem(w_quotient_or_rem), .in_tag(w_in_tag), .flush(w_flush),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result), .out_tag(w_out_tag)
    );

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   t_issue = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic s, input logic q,
                           input logic [4:0] tg, input logic [31:0] exp, input int lat);
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        e.res = {32'h0, exp};
        e.tag = tg;
        e.lat = lat;
        sbq.push_back(e);
        dividend = a; divisor = b; is_signed = s; quotient_or_rem = q; in_tag = tg;
        in_valid = 1'b1;
        t_issue  = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect32(input string name);
        exp_t e;
        int   n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        check({name, "_valid"}, out_valid, 1);
        check({name, "_latency"}, cyc - t_issue, e.lat);
        check({name, "_result"}, result, e.res);
        check({name, "_tag"}, out_tag, e.tag);
        if (out_ready) begin
            @(negedge clk);
            check({name, "_in_ready_after"}, in_ready, 1);
        end
    endtask

    task automatic op64(input string name, input logic [63:0] a, input logic [63:0] b,
                        input logic q, input logic [4:0] tg, input logic [63:0] exp);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        e.res = exp; e.tag = tg; e.lat = 66;
        sbq.push_back(e);
        w_dividend = a; w_divisor = b; w_is_signed = 1'b0; w_quotient_or_rem = q; w_in_tag = tg;
        w_in_valid = 1'b1;
        t_issue    = cyc;
        @(negedge clk);
        w_in_valid = 1'b0;
        while (!w_out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        e = sbq.pop_front();
        check({name, "_valid"}, w_out_valid, 1);
        check({name, "_latency"}, cyc - t_issue, e.lat);
        check({name, "_result"}, w_result, e.res);
        check({name, "_tag"}, w_out_tag, e.tag);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, ex;
        logic signed [31:0] sa, sb;
        logic q, seen;

        in_valid = 0; dividend = 0; divisor = 0; is_signed = 0; quotient_or_rem = 0;
        in_tag = 0; flush = 0; out_ready = 1;
        w_in_valid = 0; w_dividend = 0; w_divisor = 0; w_is_signed = 0; w_quotient_or_rem = 0;
        w_in_tag = 0; w_flush = 0; w_out_ready = 1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_w_out_valid", w_out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // unsigned basics
        issue32(32'd100, 32'd7, 1'b0, 1'b1, 5'd3, 32'd14, 34);
        collect32("divu_100_7");
        issue32(32'd100, 32'd7, 1'b0, 1'b0, 5'd4, 32'd2, 34);
        collect32("remu_100_7");

        // signed sign combinations
        issue32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 5'd5, 32'hFFFFFFFD, 34);
        collect32("div_neg7_2");
        issue32(32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 5'd6, 32'hFFFFFFFF, 34);
        collect32("rem_neg7_2");
        issue32(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 5'd7, 32'hFFFFFFFD, 34);
        collect32("div_7_neg2");

        // divide by zero and signed overflow
        issue32(32'h12345678, 32'd0, 1'b1, 1'b1, 5'd8, 32'hFFFFFFFF, SPEC_LAT);
        collect32("div_by_zero");
        issue32(32'h12345678, 32'd0, 1'b1, 1'b0, 5'd9, 32'h12345678, SPEC_LAT);
        collect32("rem_by_zero");
        issue32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd10, 32'h80000000, SPEC_LAT);
        collect32("div_ovf");
        issue32(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 5'd11, 32'h0, SPEC_LAT);
        collect32("rem_ovf");

        // random unsigned and signed against the language operators
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom_range(1, 70000);
            q = i[0];
            if (i < 3) begin
                ex = q ? a / b : a % b;
                issue32(a, b, 1'b0, q, 5'(12 + i), ex, 34);
            end else begin
                sa = $signed(a);
                sb = (i == 4) ? -$signed(b) : $signed(b);
                ex = q ? 32'(sa / sb) : 32'(sa % sb);
                issue32(a, 32'(sb), 1'b1, q, 5'(12 + i), ex, 34);
            end
            collect32("random");
        end

        // backpressure in DONE
        out_ready = 1'b0;
        issue32(32'd1000, 32'd10, 1'b0, 1'b1, 5'd21, 32'd100, 34);
        collect32("stall");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", out_valid, 1);
            check("stall_result", result, 32'd100);
            check("stall_tag", out_tag, 5'd21);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in_ready", in_ready, 1);
        check("stall_release_out_valid", out_valid, 0);

        // flush in the 10th CALC cycle
        issue32(32'd5000, 32'd3, 1'b0, 1'b1, 5'd22, 32'd0, 0);
        void'(sbq.pop_back());
        while (cyc < t_issue + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_out_valid", seen, 0);

        // reset in the middle of CALC
        issue32(32'd5000, 32'd3, 1'b0, 1'b1, 5'd23, 32'd0, 0);
        void'(sbq.pop_back());
        while (cyc < t_issue + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 0);
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_result", result, 0);
        check("midrst_out_tag", out_tag, 0);
        @(negedge clk);
        check("midrst_in_ready_after", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst_no_out_valid", seen, 0);

        // 64-bit instance
        op64("divu64", 64'h7FFFFFFFFFFFFFFF, 64'd3, 1'b1, 5'd24, 64'h2AAAAAAAAAAAAAAA);
        op64("remu64", 64'h7FFFFFFFFFFFFFFF, 64'd3, 1'b0, 5'd25, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/z_core_div_unit_p.md
Z_CORE_DIV_UNIT_P -- requirements
Module: z_core_div_unit_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 5, width of the tag carried from request to result.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have ports dividend, divisor  input  XLEN  operands.
REQ-008 SHALL have ports is_signed, quotient_or_rem  input  1  1=DIV/REM, 0=DIVU/REMU; 1=quotient, 0=remainder.
REQ-009 SHALL have port in_tag  input  TAG_W  request tag.
REQ-010 SHALL have port flush  input  1  abort any operation in progress.
REQ-011 SHALL have ports out_valid  output  1, out_ready  input  1  result handshake.
REQ-012 SHALL have ports result  output  XLEN, out_tag  output  TAG_W  result and echoed tag.

Function
REQ-013 SHALL implement states IDLE, CALC, FIXUP, DONE; in_ready=1 only in IDLE.
REQ-014 SHALL accept a request in cycle T when in_valid&&in_ready&&!flush, latching all operand, mode and tag inputs.
REQ-015 SHALL perform one restoring subtract-and-shift step per CALC cycle on |dividend|, |divisor| (absolute value only when is_signed), XLEN CALC cycles total.
REQ-016 SHALL apply sign correction in FIXUP: quotient negated when operand signs differ, remainder takes dividend sign.
REQ-017 SHALL produce RISC-V results: x/0 gives quotient all-ones, remainder x; signed -2^(XLEN-1)/-1 gives quotient -2^(XLEN-1), remainder 0.
REQ-018 SHALL assert out_valid first in cycle T+XLEN+2 for normal operations, with result/out_tag stable while in DONE.
REQ-019 SHALL hold DONE until out_valid&&out_ready, then go to IDLE next cycle; no new request is accepted in that same cycle.
REQ-020 SHALL on flush, from any state, go to IDLE next cycle with out_valid=0; a request presented with flush is not accepted.
REQ-021 SHALL keep the iteration counter width $clog2(XLEN)+1, without wrap before XLEN steps.

Reset
REQ-022 SHALL on rst: state=IDLE, in_ready=0 during rst and 1 in the following cycle, out_valid=0, result=0, out_tag=0, all internal registers cleared.
REQ-023 SHALL abandon any operation when rst is asserted mid-operation, with no result emitted.

Configuration
REQ-024 SHALL, with Z_CORE_DIV_EARLY_OUT_EN defined, route divide-by-zero and signed overflow from acceptance straight to FIXUP, giving out_valid in cycle T+2.
REQ-025 SHALL, without Z_CORE_DIV_EARLY_OUT_EN, run those cases through all XLEN CALC cycles (out_valid at T+XLEN+2) with identical result values.

Structure
REQ-026 SHALL place the state encoding and the XLEN/TAG_W default localparams in package z_core_div_pkg.
REQ-027 SHALL use one combinational sub-module z_core_div_sign_fix for abs-value and result sign correction, instantiated once for operands and once for results.

Verification
REQ-028 XLEN=32: DIVU 100/7 -> 14, REMU -> 2; out_valid at T+34, out_tag echoed.
REQ-029 DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 DIV 0x12345678/0 -> 0xFFFFFFFF, REM -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; latency 2 with macro, 34 without.
REQ-031 out_ready held low 5 cycles in DONE -> result, out_valid and out_tag stable, in_ready=0; then out_ready=1 -> in_ready=1 next cycle.
REQ-032 flush in 10th CALC cycle -> out_valid never asserted, in_ready=1 next cycle; rst mid-CALC -> same, outputs zero.
REQ-033 XLEN=64: DIVU 0x7FFFFFFFFFFFFFFF/3 -> 0x2AAAAAAAAAAAAAAA, REMU -> 1, out_valid at T+66.
